// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder/subtractor with a registered ripple carry.
// It consumes DIGIT bits of each operand per clock, LSB digit first. After
// WIDTH/DIGIT steps it pulses done and presents sum, cout and ovf, which then
// hold until the next completion or reset.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [DIGIT-1:0]       dsum_s;
  logic [DIGIT:0]         chain_s;
  logic [WIDTH+DIGIT-1:0] cat_s;
  logic [WIDTH-1:0]       acc_d;
  logic                   cmsb_s;
  logic                   last_s;

  // One DIGIT-wide ripple chain fed by the low digit of each operand and the carry register.
  always_comb begin
    dsum_s     = {DIGIT{1'b0}};
    chain_s    = {(DIGIT+1){1'b0}};
    chain_s[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      dsum_s[i]    = a_q[i] ^ b_q[i] ^ chain_s[i];
      chain_s[i+1] = (a_q[i] & b_q[i]) | (chain_s[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // The new digit enters at the top of the accumulator. On the final step
  // the chain's top stage is the operand MSB, so its carry-in is the carry into the MSB.
  assign cat_s  = {dsum_s, acc_q};
  assign acc_d  = cat_s[WIDTH+DIGIT-1:DIGIT];
  assign cmsb_s = chain_s[DIGIT-1];
  assign last_s = (cnt_q == CW'(N - 1));

  // Control FSM and datapath registers; results update only on the completion edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            acc_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          acc_q   <= acc_d;
          carry_q <= chain_s[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          if (last_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= acc_d;
            cout_q  <= chain_s[DIGIT];
            ovf_q   <= cmsb_s ^ chain_s[DIGIT];
          end else begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
